// File: rtl/uart_rx_ctrl_if.sv
// Bus bundle between the UART RX frame controller, the RX line/oversampler
// side (master) and the controller itself (slave).
interface uart_rx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  RX_IN;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  SampledBit;
    logic [2:0]            EdgeCounter;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_ERR;
    logic                  STP_ERR;
    logic                  BUSY;

    modport master (
        output RX_IN, PAR_EN, PAR_TYP, SampledBit,
        input  EdgeCounter, P_DATA, DATA_VALID, PAR_ERR, STP_ERR, BUSY
    );

    modport slave (
        input  RX_IN, PAR_EN, PAR_TYP, SampledBit,
        output EdgeCounter, P_DATA, DATA_VALID, PAR_ERR, STP_ERR, BUSY
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller, 8x oversampling. Drives the sub-bit phase
// to the oversampler, consumes its majority-voted bit once per bit period
// (phase 7) and sequences start / data / optional parity / stop.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic           CLK,
    input  logic           RST,
    uart_rx_ctrl_if.slave  bus
);
    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state, state_nxt;
    logic [2:0]            ecnt;
    logic [CW-1:0]         bitcnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  pen_q, ptyp_q, par_fail;
    logic                  bit_edge, last_bit, par_exp, stop_eval;
    logic                  dv_d, pe_d, se_d, busy_d;

    // Phase 7 is where the oversampler's vote is valid; the wrap after it is
    // the bit boundary.
    assign bit_edge  = (ecnt == 3'd7);
    assign last_bit  = (bitcnt == CW'(DATA_WIDTH - 1));
    assign par_exp   = (^shreg) ^ ptyp_q;
    assign stop_eval = (state == STOP) && bit_edge;

    assign bus.EdgeCounter = ecnt;

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode; only the phase-7 edge moves a busy frame forward.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (!bus.RX_IN) state_nxt = START;
            START:   if (bit_edge) state_nxt = bus.SampledBit ? IDLE : DATA;
            DATA:    if (bit_edge && last_bit) state_nxt = pen_q ? PARITY : STOP;
            PARITY:  if (bit_edge) state_nxt = STOP;
            STOP:    if (bit_edge) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs; strobes only on the stop edge.
    always_comb begin
        dv_d   = stop_eval & bus.SampledBit & ~par_fail;
        pe_d   = stop_eval & par_fail;
        se_d   = stop_eval & ~bus.SampledBit;
        busy_d = (state_nxt != IDLE);
    end

    // Frame datapath: phase counter, bit index, shift register, captured
    // parity configuration and parity result.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ecnt     <= '0;
            bitcnt   <= '0;
            shreg    <= '0;
            pen_q    <= 1'b0;
            ptyp_q   <= 1'b0;
            par_fail <= 1'b0;
        end else if (state == IDLE) begin
            // The detection edge is phase 0 of the start bit, so the counter
            // leaves IDLE already at 1.
            if (!bus.RX_IN) begin
                ecnt     <= 3'd1;
                pen_q    <= bus.PAR_EN;
                ptyp_q   <= bus.PAR_TYP;
                par_fail <= 1'b0;
            end else begin
                ecnt <= '0;
            end
        end else begin
            ecnt <= ecnt + 3'd1;
            if (bit_edge) begin
                unique case (state)
                    START:  bitcnt <= '0;
                    DATA: begin
                        shreg[bitcnt] <= bus.SampledBit;
                        if (!last_bit) bitcnt <= bitcnt + CW'(1);
                    end
                    PARITY: par_fail <= (bus.SampledBit != par_exp);
                    default: ;
                endcase
            end
        end
    end

    // Output registers; P_DATA only moves on a good frame.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bus.P_DATA     <= '0;
            bus.DATA_VALID <= 1'b0;
            bus.PAR_ERR    <= 1'b0;
            bus.STP_ERR    <= 1'b0;
            bus.BUSY       <= 1'b0;
        end else begin
            bus.DATA_VALID <= dv_d;
            bus.PAR_ERR    <= pe_d;
            bus.STP_ERR    <= se_d;
            bus.BUSY       <= busy_d;
            if (dv_d) bus.P_DATA <= shreg;
        end
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed frames, a timeline model of
// the frame (cycle offset from the start-bit detection edge) compared against
// the DUT on every cycle, plus literal expectations per frame.
module tb_uart_rx_ctrl;
    localparam int DW = 8;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    uart_rx_ctrl_if #(.DATA_WIDTH(DW)) bus ();
    uart_rx_ctrl #(.DATA_WIDTH(DW)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    // Ideal oversampler: the line is held steady across every bit period,
    // so the vote equals the line level.
    assign bus.SampledBit = bus.RX_IN;

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int edge_idx();
        return int'($time / 10);
    endfunction

    // ---------------- behavioural model ----------------
    // A frame is a timeline of n = 0.. cycles after the detection edge; bit k
    // is decided at n = 8k+7. Start is bit 0, data bits 1..DW, then parity
    // (if enabled), then stop.
    bit              m_busy = 1'b0;
    int              m_n = 0;
    logic [DW-1:0]   m_pdata = '0;
    bit              m_dv = 1'b0, m_pe = 1'b0, m_se = 1'b0;
    bit              m_pen = 1'b0, m_ptyp = 1'b0;
    bit              smp [0:DW+2];
    int              m_k;
    logic [DW-1:0]   m_data;
    bit              m_pfail;
    int              m_dv_cnt = 0, m_pe_cnt = 0, m_se_cnt = 0;
    int              m_evt_edge = -1;
    logic [DW-1:0]   m_dv_log [$];

    initial forever begin
        @(posedge CLK or posedge RST);
        if (RST) begin
            m_busy = 1'b0; m_n = 0; m_pdata = '0;
            m_dv = 1'b0; m_pe = 1'b0; m_se = 1'b0;
        end else begin
            m_dv = 1'b0; m_pe = 1'b0; m_se = 1'b0;
            if (!m_busy) begin
                if (bus.RX_IN == 1'b0) begin
                    m_busy = 1'b1; m_n = 0;
                    m_pen = bus.PAR_EN; m_ptyp = bus.PAR_TYP;
                end
            end else begin
                m_n++;
                if (m_n % 8 == 7) begin
                    m_k = m_n / 8;
                    smp[m_k] = bus.SampledBit;
                    if (m_k == 0) begin
                        if (bus.SampledBit) m_busy = 1'b0;
                    end else if (m_k == DW + 1 + (m_pen ? 1 : 0)) begin
                        m_data = '0;
                        for (int i = 0; i < DW; i++) m_data[i] = smp[i + 1];
                        m_pfail = m_pen && (smp[DW + 1] != ((^m_data) ^ m_ptyp));
                        m_se = !bus.SampledBit;
                        m_pe = m_pfail;
                        m_dv = bus.SampledBit && !m_pfail;
                        if (m_dv) begin
                            m_pdata = m_data;
                            m_dv_log.push_back(m_data);
                            m_dv_cnt++;
                        end
                        if (m_pe) m_pe_cnt++;
                        if (m_se) m_se_cnt++;
                        m_evt_edge = edge_idx();
                        m_busy = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge CLK);
        chk("EdgeCounter", bus.EdgeCounter, m_busy ? (m_n + 1) % 8 : 0);
        chk("BUSY",        bus.BUSY,        m_busy);
        chk("DATA_VALID",  bus.DATA_VALID,  m_dv);
        chk("PAR_ERR",     bus.PAR_ERR,     m_pe);
        chk("STP_ERR",     bus.STP_ERR,     m_se);
        chk("P_DATA",      bus.P_DATA,      m_pdata);
    end

    // ---------------- stimulus ----------------
    int s_dv, s_pe, s_se;

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic snap();
        s_dv = m_dv_cnt; s_pe = m_pe_cnt; s_se = m_se_cnt;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit pen, input bit ptyp,
                              input bit pbit, input bit stopb, input bit flip_cfg,
                              output int t0);
        bus.PAR_EN = pen; bus.PAR_TYP = ptyp; bus.RX_IN = 1'b0;
        tick(1);
        t0 = edge_idx();
        tick(7);
        for (int i = 0; i < DW; i++) begin
            bus.RX_IN = d[i];
            if (flip_cfg && i == 3) begin
                bus.PAR_TYP = ~ptyp; bus.PAR_EN = ~pen;
            end
            tick(8);
        end
        if (pen) begin
            bus.RX_IN = pbit;
            tick(8);
        end
        bus.RX_IN = stopb;
        tick(8);
        bus.RX_IN = 1'b1;
    endtask

    task automatic expect_frame(input string nm, input int t0, input int lat,
                                input int dvx, input int pex, input int sex,
                                input logic [7:0] pd);
        chk({nm, "_stop_edge"}, m_evt_edge - t0, lat);
        chk({nm, "_dv_pulses"}, m_dv_cnt - s_dv, dvx);
        chk({nm, "_pe_pulses"}, m_pe_cnt - s_pe, pex);
        chk({nm, "_se_pulses"}, m_se_cnt - s_se, sex);
        chk({nm, "_model_pdata"}, m_pdata, pd);
        chk({nm, "_dut_pdata"}, bus.P_DATA, pd);
        chk({nm, "_busy_after"}, bus.BUSY, 0);
    endtask

    initial begin
        int t0, t1, nlog;
        bus.RX_IN = 1'b1; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
        tick(3);
        chk("rst_pdata", bus.P_DATA, 0);
        chk("rst_busy", bus.BUSY, 0);
        chk("rst_ec", bus.EdgeCounter, 0);
        chk("rst_dv", bus.DATA_VALID, 0);
        RST = 1'b0;
        tick(3);

        snap(); send_frame(8'hA5, 0, 0, 0, 1, 0, t0); tick(2);
        expect_frame("a5_nopar", t0, 79, 1, 0, 0, 8'hA5);

        snap(); send_frame(8'h3C, 1, 0, 0, 1, 0, t0); tick(2);
        expect_frame("3c_even_ok", t0, 87, 1, 0, 0, 8'h3C);

        snap(); send_frame(8'h3C, 1, 0, 1, 1, 0, t0); tick(2);
        expect_frame("3c_even_bad", t0, 87, 0, 1, 0, 8'h3C);

        snap(); send_frame(8'h01, 1, 1, 0, 1, 0, t0); tick(2);
        expect_frame("01_odd_ok", t0, 87, 1, 0, 0, 8'h01);

        snap(); send_frame(8'h01, 1, 1, 0, 1, 1, t0); tick(2);
        expect_frame("01_odd_cfgflip", t0, 87, 1, 0, 0, 8'h01);

        snap(); send_frame(8'h55, 0, 0, 0, 0, 0, t0); tick(2);
        expect_frame("55_stop0", t0, 79, 0, 0, 1, 8'h01);

        // Start glitch: two low clocks, then the line returns high.
        snap();
        bus.PAR_EN = 1'b0; bus.RX_IN = 1'b0;
        tick(1);
        tick(1);
        bus.RX_IN = 1'b1;
        tick(5);
        chk("glitch_busy_t6", bus.BUSY, 1);
        chk("glitch_ec_t6", bus.EdgeCounter, 7);
        tick(1);
        chk("glitch_busy_t7", bus.BUSY, 0);
        chk("glitch_ec_t7", bus.EdgeCounter, 0);
        tick(3);
        chk("glitch_no_dv", m_dv_cnt - s_dv, 0);
        chk("glitch_no_err", (m_pe_cnt - s_pe) + (m_se_cnt - s_se), 0);

        // Reset in the middle of data bit 4.
        snap();
        bus.PAR_EN = 1'b0; bus.RX_IN = 1'b0;
        tick(8);
        for (int i = 0; i < 4; i++) begin
            bus.RX_IN = 1'b1; tick(8);
        end
        tick(3);
        #2 RST = 1'b1;
        #1;
        chk("abort_pdata", bus.P_DATA, 0);
        chk("abort_busy", bus.BUSY, 0);
        chk("abort_ec", bus.EdgeCounter, 0);
        chk("abort_dv", bus.DATA_VALID, 0);
        chk("abort_model_pdata", m_pdata, 0);
        bus.RX_IN = 1'b1;
        tick(2);
        RST = 1'b0;
        tick(3);
        chk("abort_no_strobes", (m_dv_cnt - s_dv) + (m_pe_cnt - s_pe) + (m_se_cnt - s_se), 0);

        snap(); send_frame(8'h81, 0, 0, 0, 1, 0, t0); tick(2);
        expect_frame("81_after_rst", t0, 79, 1, 0, 0, 8'h81);

        // Back-to-back frames: the second start bit follows the stop edge.
        snap(); nlog = m_dv_log.size();
        send_frame(8'h12, 0, 0, 0, 1, 0, t0);
        send_frame(8'h34, 0, 0, 0, 1, 0, t1);
        tick(2);
        expect_frame("b2b_second", t1, 79, 2, 0, 0, 8'h34);
        chk("b2b_log_size", m_dv_log.size() - nlog, 2);
        if (m_dv_log.size() >= nlog + 2) begin
            chk("b2b_first_word", m_dv_log[nlog], 8'h12);
            chk("b2b_second_word", m_dv_log[nlog + 1], 8'h34);
        end

        tick(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Frame controller for the UART receive path, 8x oversampling.
- Generates the per-bit 3-bit EdgeCounter that drives the oversampling/majority stage.
- Consumes the stage's SampledBit and sequences start, data, optional parity and stop bits.
- Delivers the received byte with valid/error strobes to the downstream consumer.
- Sits between the RX line (already synchronized to CLK upstream) and the oversampler/consumer.

Parameters:
DATA_WIDTH, 8, number of data bits per frame, LSB first.

Ports:
CLK  input  1  system clock; 8 CLK cycles per UART bit.
RST  input  1  asynchronous, active-high reset.
RX_IN  input  1  serial line, synchronous to CLK, idle high.
PAR_EN  input  1  1 = frame carries a parity bit.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
SampledBit  input  1  majority-voted bit from the oversampler; valid while EdgeCounter==7.
EdgeCounter  output  3  sub-bit phase driven to the oversampler.
P_DATA  output  DATA_WIDTH  last good received word.
DATA_VALID  output  1  1-cycle strobe: P_DATA updated.
PAR_ERR  output  1  1-cycle strobe: parity mismatch in completed frame.
STP_ERR  output  1  1-cycle strobe: stop bit sampled 0.
BUSY  output  1  1 whenever state != IDLE.

Behaviour:
- Interface: one clock CLK; RST asynchronous, active-high.
- Reset values: state IDLE, EdgeCounter 0, bit counter 0, shift register 0, P_DATA 0, DATA_VALID/PAR_ERR/STP_ERR/BUSY 0.
- Reset asserted mid-frame aborts immediately. No strobes are produced for the aborted frame. P_DATA returns to 0.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: EdgeCounter held at 0.
  - On a clock edge with RX_IN==0: go to START and set EdgeCounter to 1. The detection cycle counts as edge 0 of the start bit.
  - PAR_EN and PAR_TYP are captured at this edge and held for the whole frame. Mid-frame changes are ignored.
- Non-IDLE states: EdgeCounter increments by 1 every clock and wraps 7->0. The wrap is the bit boundary.
- Evaluation happens only on a clock edge where EdgeCounter==7, using SampledBit:
  - START:
    - SampledBit==0: go to DATA with bit counter 0.
    - SampledBit==1 (glitch): go to IDLE with EdgeCounter 0. No strobes.
  - DATA:
    - Write shift_reg[bit counter] <= SampledBit.
    - At bit counter==DATA_WIDTH-1: go to PARITY if the captured PAR_EN is 1, else go to STOP.
    - Otherwise bit counter +1.
  - PARITY:
    - Expected bit = XOR of shift_reg, inverted when the captured PAR_TYP is 1.
    - Latch mismatch into an internal par_fail flag. Go to STOP.
  - STOP: go to IDLE with EdgeCounter 0. On the same edge, register:
    - STP_ERR <= ~SampledBit
    - PAR_ERR <= par_fail
    - DATA_VALID <= SampledBit & ~par_fail
    - P_DATA <= shift_reg, only when DATA_VALID is set.
- Strobes are high for exactly one cycle, the cycle after the STOP evaluation edge.
- P_DATA holds its value until the next valid frame.
- Latency: detection edge t0 -> STOP evaluation at t0+79 without parity, t0+87 with parity. Strobes are visible in the following cycle.
- Back-to-back frames: IDLE can detect a new start bit on the first clock after returning to IDLE. The clock edge on which STOP returns to IDLE is not checked for RX_IN==0.
- par_fail is cleared at every IDLE->START transition.
- BUSY = (state != IDLE), registered together with the state.

Test Plan:
- No parity, 0xA5 sent LSB first, stop=1 -> DATA_VALID pulse at t0+80, P_DATA=0xA5, PAR_ERR=0, STP_ERR=0, BUSY low afterwards.
- PAR_EN=1, PAR_TYP=0, 0x3C with parity bit 0 -> DATA_VALID at t0+88, P_DATA=0x3C. Repeat with parity bit 1 -> PAR_ERR=1, DATA_VALID=0, P_DATA unchanged.
- PAR_EN=1, PAR_TYP=1, 0x01 with parity bit 0 -> valid, P_DATA=0x01. Toggle PAR_TYP mid-frame -> result unchanged.
- 0x55 with stop bit 0 -> STP_ERR=1, DATA_VALID=0, P_DATA keeps its previous value.
- RX_IN low for 2 clocks then high -> START evaluates SampledBit=1 -> back to IDLE at t0+7, no strobes, EdgeCounter=0.
- RST asserted at data bit 4 of a frame -> all outputs 0 immediately. After release, a clean 0x81 frame gives P_DATA=0x81. Two frames sent back-to-back (0x12 then 0x34) -> two DATA_VALID pulses, 0x12 then 0x34.
